i2c_slave_core: RTL and testbench

//  I2C target (slave) bridging an external I2C bus to an 8-bit register/memory port.

---
 rtl/i2c_slave_pkg.sv | 24 ++
 rtl/i2c_sync_edge.sv | 33 +++
 rtl/i2c_slave_core.sv | 231 +++++++++++++++++++++++
 tb/tb_i2c_slave_core.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_slave_pkg.sv
// Shared definitions for the I2C target core.
// Contents: FSM state enum, default 7-bit device address, ACK/NACK bus levels.
package i2c_slave_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StDevAddr,
        StAckDev,
        StRegAddr,
        StAckReg,
        StWrData,
        StAckWr,
        StRdData,
        StRdAck,
        StWaitStop
    } state_e;

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h50;

    // Bus level in the acknowledge slot
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer with an extra history flop for edge detection.
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-high reset (flops reset to the idle-bus level 1)
//   din   in   asynchronous input (SCL or SDA pin)
//   level out  synchronized level
//   rise  out  one-clk pulse on a synchronized 0->1 transition
//   fall  out  one-clk pulse on a synchronized 1->0 transition
module i2c_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    // [0],[1] form the synchronizer, [2] holds the previous synchronized value
    logic [2:0] sr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= 3'b111;
        end else begin
            sr_q <= {sr_q[1:0], din};
        end
    end

    assign level = sr_q[1];
    assign rise  = sr_q[1] & ~sr_q[2];
    assign fall  = ~sr_q[1] & sr_q[2];

endmodule

// File: rtl/i2c_slave_core.sv
// I2C target bridging the bus to an 8-bit register/memory port.
// Ports:
//   clk      in     system clock (>= 16x SCL)
//   rst      in     asynchronous active-high reset
//   i2c_scl  in     bus clock from master
//   i2c_sda  inout  open-drain bus data
//   rd_data  in     read byte, valid the clk after rd_en
//   wr_en    out    one-clk write strobe
//   rd_en    out    one-clk read request
//   wr_data  out    write byte, valid while wr_en=1
//   addr     out    register pointer for reads and writes
module i2c_slave_core
    import i2c_slave_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i2c_scl,
    inout  wire        i2c_sda,
    input  logic [7:0] rd_data,
    output logic       wr_en,
    output logic       rd_en,
    output logic [7:0] wr_data,
    output logic [7:0] addr
);

    logic scl_s, scl_rise, scl_fall;
    logic sda_s, sda_rise, sda_fall;

    i2c_sync_edge u_scl_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (i2c_scl),
        .level (scl_s),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_sync_edge u_sda_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (i2c_sda),
        .level (sda_s),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    logic start_cond, stop_cond;
    assign start_cond = sda_fall & scl_s;
    assign stop_cond  = sda_rise & scl_s;

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       sda_oe_q, sda_oe_d;
    logic       wr_en_q, wr_en_d;
    logic       rd_en_q, rd_en_d;
    logic       load_q, load_d;
    logic       rw_q, rw_d;
    logic [7:0] shift_in;

    assign shift_in = {shift_q[6:0], sda_s};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            addr_q    <= '0;
            wr_data_q <= '0;
            sda_oe_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            load_q    <= 1'b0;
            rw_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            sda_oe_q  <= sda_oe_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            load_q    <= load_d;
            rw_q      <= rw_d;
        end
    end

    // In the ACK states sda_oe_q doubles as the phase flag: the first scl_fall
    // starts driving the ACK, the second one ends the slot.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        sda_oe_d  = sda_oe_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        load_d    = rd_en_q;
        rw_d      = rw_q;

        if (load_q) begin
            shift_d = rd_data;
        end

        if (start_cond) begin
            state_d   = StDevAddr;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else if (stop_cond) begin
            state_d  = StIdle;
            sda_oe_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StWaitStop: begin
                end
                StDevAddr: begin
                    if (scl_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rw_d    = sda_s;
                            state_d = (shift_in[7:1] == DEV_ADDR) ? StAckDev : StWaitStop;
                        end
                    end
                end
                StAckDev: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else if (!rw_q) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = StRegAddr;
                        end
                    end else if (scl_rise && sda_oe_q && rw_q) begin
                        // Fetch early so the MSB is ready when the ACK slot ends
                        rd_en_d   = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = StRdData;
                    end
                end
                StRegAddr: begin
                    if (scl_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            addr_d  = shift_in;
                            state_d = StAckReg;
                        end
                    end
                end
                StAckReg: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = StWrData;
                        end
                    end
                end
                StWrData: begin
                    if (scl_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            wr_data_d = shift_in;
                            wr_en_d   = 1'b1;
                            state_d   = StAckWr;
                        end
                    end
                end
                StAckWr: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            addr_d    = addr_q + 8'd1;
                            bit_cnt_d = '0;
                            state_d   = StWrData;
                        end
                    end
                end
                StRdData: begin
                    if (scl_fall) begin
                        sda_oe_d = ~shift_q[7];
                        shift_d  = {shift_q[6:0], 1'b0};
                    end else if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = StRdAck;
                        end
                    end
                end
                StRdAck: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                    end else if (scl_rise) begin
                        if (sda_s == ACK) begin
                            addr_d    = addr_q + 8'd1;
                            rd_en_d   = 1'b1;
                            bit_cnt_d = '0;
                            state_d   = StRdData;
                        end else begin
                            state_d = StWaitStop;
                        end
                    end
                end
                default: begin
                    state_d  = StIdle;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    assign i2c_sda = sda_oe_q ? 1'b0 : 1'bz;
    assign wr_en   = wr_en_q;
    assign rd_en   = rd_en_q;
    assign wr_data = wr_data_q;
    assign addr    = addr_q;

endmodule

// File: tb/tb_i2c_slave_core.sv
// Directed bench for i2c_slave_core: bit-level I2C master, SDA pullup, 256x8 memory model.
`timescale 1ns/1ps
module tb_i2c_slave_core;

    localparam int Q = 250;  // quarter SCL period in ns (1 us bit time)

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    logic       mem_init = 1'b1;
    wire        sda_bus;
    logic [7:0] rd_data;
    logic       wr_en, rd_en;
    logic [7:0] wr_data, addr;

    assign sda_bus = m_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    i2c_slave_core #(.DEV_ADDR(7'h50)) dut (
        .clk     (clk),
        .rst     (rst),
        .i2c_scl (scl),
        .i2c_sda (sda_bus),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .wr_data (wr_data),
        .addr    (addr)
    );

    always #10 clk = ~clk;

    logic [7:0] mem [256];
    int         wr_cnt = 0;
    int         rd_cnt = 0;
    int         both_cnt = 0;
    logic [7:0] wr_log [$];
    logic [7:0] rd_log [$];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
            rd_data <= 8'h00;
        end else begin
            if (wr_en) mem[addr] <= wr_data;
            if (rd_en) rd_data <= mem[addr];
        end
    end

    always @(negedge clk) begin
        if (wr_en) begin
            wr_cnt++;
            wr_log.push_back(addr);
        end
        if (rd_en) begin
            rd_cnt++;
            rd_log.push_back(addr);
        end
        if (wr_en && rd_en) both_cnt++;
    end

    int n_chk = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---- master model ----
    task automatic i2c_start();
        m_low = 1'b0; #Q;
        scl   = 1'b1; #Q;
        m_low = 1'b1; #Q;
        scl   = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        m_low = 1'b1; #Q;
        scl   = 1'b1; #Q;
        m_low = 1'b0; #(4 * Q);
    endtask

    task automatic i2c_bit(input logic b, output logic s);
        m_low = ~b; #Q;
        scl   = 1'b1; #Q;
        s     = sda_bus; #Q;
        scl   = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) i2c_bit(d[i], s);
        i2c_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) i2c_bit(1'b1, d[i]);
        i2c_bit(mack, s);
    endtask

    logic       a0, a1, a2, a3;
    logic [7:0] rb, rb2;
    logic       s;

    initial begin
        repeat (5) @(negedge clk);
        rst = 1'b0;
        mem_init = 1'b0;
        @(negedge clk);
        check_eq("rst_wr_en", 32'(wr_en), 32'd0);
        check_eq("rst_rd_en", 32'(rd_en), 32'd0);
        check_eq("rst_wr_data", 32'(wr_data), 32'h00);
        check_eq("rst_addr", 32'(addr), 32'h00);
        check_eq("rst_sda", 32'(sda_bus), 32'd1);

        // Single write 0xDA -> 0xB1
        i2c_start();
        write_byte(8'hA0, a0);
        write_byte(8'hB1, a1);
        write_byte(8'hDA, a2);
        i2c_stop();
        @(negedge clk);
        check_eq("wr_ack_dev", 32'(a0), 32'd0);
        check_eq("wr_ack_reg", 32'(a1), 32'd0);
        check_eq("wr_ack_data", 32'(a2), 32'd0);
        check_eq("wr_count", 32'(wr_cnt), 32'd1);
        check_eq("wr_addr", 32'(wr_log[0]), 32'hB1);
        check_eq("wr_mem", 32'(mem[8'hB1]), 32'hDA);
        check_eq("wr_addr_post", 32'(addr), 32'hB2);

        // Random read via repeated START
        i2c_start();
        write_byte(8'hA0, a0);
        write_byte(8'hB1, a1);
        i2c_start();
        write_byte(8'hA1, a2);
        read_byte(1'b1, rb);
        i2c_stop();
        @(negedge clk);
        check_eq("rd_ack_dev", 32'(a0), 32'd0);
        check_eq("rd_ack_reg", 32'(a1), 32'd0);
        check_eq("rd_ack_dev_r", 32'(a2), 32'd0);
        check_eq("rd_count", 32'(rd_cnt), 32'd1);
        check_eq("rd_addr", 32'(rd_log[0]), 32'hB1);
        check_eq("rd_data", 32'(rb), 32'hDA);
        check_eq("rd_addr_post", 32'(addr), 32'hB1);

        // Address mismatch: NACK, no strobes
        i2c_start();
        write_byte(8'hA2, a0);
        i2c_stop();
        @(negedge clk);
        check_eq("mis_nack", 32'(a0), 32'd1);
        check_eq("mis_wr_count", 32'(wr_cnt), 32'd1);
        check_eq("mis_rd_count", 32'(rd_cnt), 32'd1);

        // Burst write across the 0xFF -> 0x00 wrap
        i2c_start();
        write_byte(8'hA0, a0);
        write_byte(8'hFF, a1);
        write_byte(8'h11, a2);
        write_byte(8'h22, a3);
        i2c_stop();
        @(negedge clk);
        check_eq("bw_acks", 32'({a0, a1, a2, a3}), 32'h0);
        check_eq("bw_count", 32'(wr_cnt), 32'd3);
        check_eq("bw_addr0", 32'(wr_log[1]), 32'hFF);
        check_eq("bw_addr1", 32'(wr_log[2]), 32'h00);
        check_eq("bw_mem_ff", 32'(mem[8'hFF]), 32'h11);
        check_eq("bw_mem_00", 32'(mem[8'h00]), 32'h22);
        check_eq("bw_addr_post", 32'(addr), 32'h01);

        // Sequential read of 2 bytes from 0x10 (mem holds i^0x5A)
        i2c_start();
        write_byte(8'hA0, a0);
        write_byte(8'h10, a1);
        i2c_start();
        write_byte(8'hA1, a2);
        read_byte(1'b0, rb);
        read_byte(1'b1, rb2);
        i2c_stop();
        @(negedge clk);
        check_eq("sr_acks", 32'({a0, a1, a2}), 32'h0);
        check_eq("sr_count", 32'(rd_cnt), 32'd3);
        check_eq("sr_addr0", 32'(rd_log[1]), 32'h10);
        check_eq("sr_addr1", 32'(rd_log[2]), 32'h11);
        check_eq("sr_byte0", 32'(rb), 32'h4A);
        check_eq("sr_byte1", 32'(rb2), 32'h4B);

        // Reset in the middle of a data byte
        i2c_start();
        write_byte(8'hA0, a0);
        write_byte(8'h30, a1);
        i2c_bit(1'b0, s);
        i2c_bit(1'b1, s);
        i2c_bit(1'b1, s);
        i2c_bit(1'b1, s);
        m_low = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("mid_sda", 32'(sda_bus), 32'd1);
        check_eq("mid_addr", 32'(addr), 32'h00);
        check_eq("mid_wr_data", 32'(wr_data), 32'h00);
        check_eq("mid_wr_en", 32'(wr_en), 32'd0);
        rst = 1'b0;
        i2c_stop();
        i2c_start();
        write_byte(8'hA0, a0);
        write_byte(8'h30, a1);
        write_byte(8'h77, a2);
        i2c_stop();
        @(negedge clk);
        check_eq("post_acks", 32'({a0, a1, a2}), 32'h0);
        check_eq("post_wr_count", 32'(wr_cnt), 32'd4);
        check_eq("post_mem", 32'(mem[8'h30]), 32'h77);
        check_eq("never_both", 32'(both_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
